// File: rtl/cgra_pkg.sv
// Shared CGRA constants: default geometry, instruction field positions and
// the program-counter sequencer state encoding.
package cgra_pkg;

  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_DWIDTH_INT = 32;
  localparam int DEF_PC_W       = 12;

  // Column instruction fields
  localparam int HALT_BIT = 31;
  localparam int LOOP_BIT = 30;
  localparam int CNT_MSB  = 29;
  localparam int CNT_LSB  = 22;
  localparam int CNT_W    = CNT_MSB - CNT_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pc_col_ctrl.sv
// Per-column halt and single-level loop control. Produces the PC strobes for
// one column from its registered halt/loop state and current instruction.
module pc_col_ctrl
  import cgra_pkg::*;
#(
  parameter int DWIDTH_INT = DEF_DWIDTH_INT,
  parameter int PC_W       = DEF_PC_W
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  in_init,
  input  logic                  in_run,
  input  logic                  stall_i,
  input  logic [DWIDTH_INT-1:0] instr,
  output logic                  clken_pc,
  output logic                  load_pc,
  output logic                  incr_pc,
  output logic [PC_W-1:0]       load_value,
  output logic                  halted_nxt
);

  logic             halted_q, halted_n;
  logic             active_q, active_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             op_halt, op_loop;
  logic [CNT_W-1:0] loop_n;
  logic [PC_W-1:0]  target;
  logic             unused_bits;

  assign op_halt     = instr[HALT_BIT];
  assign op_loop     = instr[LOOP_BIT];
  assign loop_n      = instr[CNT_MSB:CNT_LSB];
  assign target      = instr[PC_W-1:0];
  assign unused_bits = ^instr[CNT_LSB-1:PC_W];
  assign halted_nxt  = halted_n;

  // Strobe decode and next halt/loop state; HALT wins over LOOP, stall freezes all.
  always_comb begin
    clken_pc   = 1'b0;
    load_pc    = 1'b0;
    incr_pc    = 1'b0;
    load_value = '0;
    halted_n   = halted_q;
    active_n   = active_q;
    cnt_n      = cnt_q;
    if (in_init) begin
      clken_pc = 1'b1;
      load_pc  = 1'b1;
      halted_n = 1'b0;
      active_n = 1'b0;
      cnt_n    = '0;
    end else if (in_run) begin
      clken_pc = ~halted_q & ~stall_i;
      if (!halted_q && !stall_i) begin
        if (op_halt) begin
          halted_n = 1'b1;
        end else if (op_loop && !active_q && loop_n != '0) begin
          active_n   = 1'b1;
          cnt_n      = loop_n - CNT_W'(1);
          load_pc    = 1'b1;
          load_value = target;
        end else if (op_loop && active_q && cnt_q != '0) begin
          cnt_n      = cnt_q - CNT_W'(1);
          load_pc    = 1'b1;
          load_value = target;
        end else if (op_loop && active_q) begin
          active_n = 1'b0;
          incr_pc  = 1'b1;
        end else begin
          incr_pc = 1'b1;
        end
      end
    end
  end

  // Halt/loop state registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      halted_q <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      halted_q <= halted_n;
      active_q <= active_n;
      cnt_q    <= cnt_n;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// CGRA program-counter sequencer: starts a run on the loader-done edge,
// drives per-column PC strobes, and ends on all-halted or cycle budget.
//
//   state | meaning
//   IDLE  | waiting for a start_i rising edge
//   INIT  | one cycle: load every PC with 0, clear column and cycle state
//   RUN   | columns execute; strobes decoded from current instructions
//   DONE  | one-cycle done_o pulse, then back to IDLE
module pc_sequencer
  import cgra_pkg::*;
#(
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int DWIDTH_INT = DEF_DWIDTH_INT,
  parameter int PC_W       = DEF_PC_W
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          start_i,
  input  logic                          stall_i,
  input  logic [DWIDTH_INT-1:0]         cycle_register,
  input  logic [NUM_COL*DWIDTH_INT-1:0] instr,
  output logic [NUM_COL-1:0]            clken_PC,
  output logic [NUM_COL-1:0]            load_PC,
  output logic [NUM_COL-1:0]            incr_PC,
  output logic [NUM_COL*PC_W-1:0]       load_value_PC,
  output logic                          done_o,
  output logic                          busy_o,
  output logic                          timeout_o
);

  seq_state_e            state_q, state_n;
  logic                  start_q, armed_q, start_rise;
  logic [DWIDTH_INT-1:0] cyc_q, cyc_n, cyc_inc;
  logic                  timeout_q, timeout_n;
  logic                  in_init, in_run;
  logic [NUM_COL-1:0]    halted_nxt;

  // armed_q blocks the first cycle after reset so a level already high at
  // release is seen as "was high" rather than as a fresh edge.
  assign start_rise = start_i & ~start_q & armed_q;
  assign in_init    = (state_q == ST_INIT) & ~areset;
  assign in_run     = (state_q == ST_RUN) & ~areset;
  assign cyc_inc    = cyc_q + DWIDTH_INT'(1);

  assign done_o    = (state_q == ST_DONE) & ~areset;
  assign busy_o    = (state_q != ST_IDLE) & ~areset;
  assign timeout_o = timeout_q & ~areset;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    pc_col_ctrl #(
      .DWIDTH_INT (DWIDTH_INT),
      .PC_W       (PC_W)
    ) u_col (
      .ap_clk     (ap_clk),
      .areset     (areset),
      .in_init    (in_init),
      .in_run     (in_run),
      .stall_i    (stall_i),
      .instr      (instr[c*DWIDTH_INT +: DWIDTH_INT]),
      .clken_pc   (clken_PC[c]),
      .load_pc    (load_PC[c]),
      .incr_pc    (incr_PC[c]),
      .load_value (load_value_PC[c*PC_W +: PC_W]),
      .halted_nxt (halted_nxt[c])
    );
  end

  // Next-state, cycle budget and timeout flag; the all-halted end wins over budget.
  always_comb begin
    state_n   = state_q;
    cyc_n     = cyc_q;
    timeout_n = timeout_q;
    case (state_q)
      ST_IDLE: if (start_rise) state_n = ST_INIT;
      ST_INIT: begin
        cyc_n     = '0;
        timeout_n = 1'b0;
        state_n   = ST_RUN;
      end
      ST_RUN: begin
        if (!stall_i) begin
          cyc_n = cyc_inc;
          if (&halted_nxt) begin
            state_n = ST_DONE;
          end else if (cycle_register != '0 && cyc_inc == cycle_register) begin
            state_n   = ST_DONE;
            timeout_n = 1'b1;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State, start-edge detector, cycle counter and timeout registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      start_q   <= start_i;
      armed_q   <= 1'b1;
      cyc_q     <= cyc_n;
      timeout_q <= timeout_n;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// programs, checked against a per-column program interpreter.
module tb_pc_sequencer;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int PW = 12;
  localparam int NEVER = 100000;

  logic              ap_clk;
  logic              areset;
  logic              start_i;
  logic              stall_i;
  logic [DW-1:0]     cycle_register;
  logic [NC*DW-1:0]  instr;
  logic [NC-1:0]     clken_PC, load_PC, incr_PC;
  logic [NC*PW-1:0]  load_value_PC;
  logic              done_o, busy_o, timeout_o;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Program memory and interpreter state
  logic [31:0] prog [NC][64];
  int          mpc    [NC];
  bit          mhalt  [NC];
  int          mjumps [NC];
  int          mcyc;
  bit          m_timeout;

  pc_sequencer #(.NUM_COL(NC), .DWIDTH_INT(DW), .PC_W(PW)) dut (
    .ap_clk         (ap_clk),
    .areset         (areset),
    .start_i        (start_i),
    .stall_i        (stall_i),
    .cycle_register (cycle_register),
    .instr          (instr),
    .clken_PC       (clken_PC),
    .load_PC        (load_PC),
    .incr_PC        (incr_PC),
    .load_value_PC  (load_value_PC),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic zero_check(input string tag);
    check({tag, "_clken"}, 64'(clken_PC), 64'(0));
    check({tag, "_load"},  64'(load_PC), 64'(0));
    check({tag, "_incr"},  64'(incr_PC), 64'(0));
    check({tag, "_lval"},  64'(load_value_PC), 64'(0));
    check({tag, "_done"},  64'(done_o), 64'(0));
    check({tag, "_busy"},  64'(busy_o), 64'(0));
  endtask

  function automatic logic [31:0] mk_loop(input int n, input int t);
    logic [31:0] w;
    w = {2'b01, 8'(n), 10'd0, 12'(t)};
    return w;
  endfunction

  task automatic clear_progs();
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < 64; a++) prog[c][a] = 32'h0;
  endtask

  task automatic halt_all_at(input int p);
    for (int c = 0; c < NC; c++) prog[c][p] = 32'h8000_0000;
  endtask

  task automatic gen_random();
    int h, p, t, n;
    for (int c = 0; c < NC; c++) begin
      for (int a = 0; a < 64; a++) prog[c][a] = $urandom & 32'h003F_FFFF;
      h = int'($urandom_range(20, 4));
      prog[c][h] = 32'h8000_0000 | ($urandom & 32'h003F_FFFF);
      if ($urandom_range(1, 0) == 1) begin
        p = int'($urandom_range(h - 1, 1));
        t = int'($urandom_range(p, 0));
        n = int'($urandom_range(4, 0));
        prog[c][p] = mk_loop(n, t);
      end
    end
  endtask

  // One run: start edge, INIT, cycle-by-cycle RUN comparison, DONE pulse.
  task automatic do_run(input string tag, input int budget, input int stall_at,
                        input int stall_len, input int abort_at, input int repulse_at,
                        output int load0_cnt);
    logic [NC-1:0]    e_clk, e_ld, e_inc;
    logic [NC*PW-1:0] e_lv, lv_mask;
    logic [31:0]      w;
    bit               ended, aborted, all_h, stl;
    int               n;
    load0_cnt = 0;
    ended = 0;
    aborted = 0;
    cycle_register = DW'(budget);
    stall_i = 1'b0;
    @(negedge ap_clk);
    start_i = 1'b1;
    next_cycle();
    start_i = 1'b0;
    #1;
    check({tag, "_init_clken"}, 64'(clken_PC), 64'(4'hF));
    check({tag, "_init_load"},  64'(load_PC), 64'(4'hF));
    check({tag, "_init_incr"},  64'(incr_PC), 64'(0));
    check({tag, "_init_lval"},  64'(load_value_PC), 64'(0));
    check({tag, "_init_busy"},  64'(busy_o), 64'(1));
    check({tag, "_init_done"},  64'(done_o), 64'(0));
    for (int c = 0; c < NC; c++) begin
      mpc[c] = 0;
      mhalt[c] = 0;
      mjumps[c] = 0;
    end
    mcyc = 0;
    for (int k = 0; k < 600 && !ended; k++) begin
      next_cycle();
      if (k == abort_at) begin
        areset = 1'b1;
        stall_i = 1'b0;
        next_cycle();
        #1;
        zero_check({tag, "_abort"});
        check({tag, "_abort_tmo"}, 64'(timeout_o), 64'(0));
        areset = 1'b0;
        m_timeout = 0;
        for (int j = 0; j < 3; j++) begin
          next_cycle();
          #1;
          check({tag, "_post_abort_done"}, 64'(done_o), 64'(0));
          check({tag, "_post_abort_busy"}, 64'(busy_o), 64'(0));
        end
        aborted = 1;
        break;
      end
      stl = (k >= stall_at) && (k < stall_at + stall_len);
      stall_i = stl;
      start_i = (k == repulse_at);
      for (int c = 0; c < NC; c++) instr[c*DW +: DW] = prog[c][mpc[c] & 63];
      #1;
      e_clk = '0; e_ld = '0; e_inc = '0; e_lv = '0; lv_mask = '0;
      for (int c = 0; c < NC; c++) begin
        if (!stl && !mhalt[c]) begin
          e_clk[c] = 1'b1;
          w = prog[c][mpc[c] & 63];
          if (w[31]) begin
            mhalt[c] = 1;
          end else if (w[30]) begin
            n = int'(w[29:22]);
            if (mjumps[c] < n) begin
              mjumps[c]++;
              e_ld[c] = 1'b1;
              e_lv[c*PW +: PW] = w[PW-1:0];
              lv_mask[c*PW +: PW] = '1;
              mpc[c] = int'(w[PW-1:0]);
            end else begin
              mjumps[c] = 0;
              e_inc[c] = 1'b1;
              mpc[c]++;
            end
          end else begin
            e_inc[c] = 1'b1;
            mpc[c]++;
          end
        end
      end
      check({tag, "_clken"}, 64'(clken_PC), 64'(e_clk));
      check({tag, "_load"},  64'(load_PC), 64'(e_ld));
      check({tag, "_incr"},  64'(incr_PC), 64'(e_inc));
      check({tag, "_lval"},  64'(load_value_PC & lv_mask), 64'(e_lv));
      check({tag, "_run_done"}, 64'(done_o), 64'(0));
      check({tag, "_run_busy"}, 64'(busy_o), 64'(1));
      check({tag, "_run_tmo"},  64'(timeout_o), 64'(0));
      if (load_PC[0]) load0_cnt++;
      if (!stl) mcyc++;
      all_h = mhalt[0] && mhalt[1] && mhalt[2] && mhalt[3];
      if (!stl && (all_h || (budget != 0 && mcyc == budget))) begin
        ended = 1;
        m_timeout = !all_h;
      end
    end
    if (!aborted) begin
      check({tag, "_bound"}, 64'(ended), 64'(1));
      next_cycle();
      stall_i = 1'b0;
      start_i = 1'b0;
      #1;
      check({tag, "_done_pulse"}, 64'(done_o), 64'(1));
      check({tag, "_done_busy"},  64'(busy_o), 64'(1));
      check({tag, "_done_tmo"},   64'(timeout_o), 64'(m_timeout));
      check({tag, "_done_clken"}, 64'(clken_PC), 64'(0));
      check({tag, "_done_strb"},  64'({load_PC, incr_PC}), 64'(0));
      next_cycle();
      #1;
      check({tag, "_idle_done"}, 64'(done_o), 64'(0));
      check({tag, "_idle_busy"}, 64'(busy_o), 64'(0));
      check({tag, "_idle_tmo"},  64'(timeout_o), 64'(m_timeout));
    end
  endtask

  initial begin
    int l0;
    areset = 1'b1;
    start_i = 1'b0;
    stall_i = 1'b0;
    cycle_register = '0;
    instr = '0;
    m_timeout = 0;
    clear_progs();
    repeat (3) next_cycle();
    #1;
    zero_check("reset");
    check("reset_tmo", 64'(timeout_o), 64'(0));

    // start_i already high at reset release must not start a run
    start_i = 1'b1;
    next_cycle();
    areset = 1'b0;
    repeat (3) next_cycle();
    #1;
    check("level_at_release_busy", 64'(busy_o), 64'(0));
    start_i = 1'b0;
    repeat (2) next_cycle();

    // All columns halt at PC 5
    clear_progs();
    halt_all_at(5);
    do_run("halt5", 0, NEVER, 0, NEVER, NEVER, l0);

    // Column 0 loops PCs 2-4 four times
    clear_progs();
    halt_all_at(5);
    prog[0][5] = 32'h0;
    prog[0][4] = mk_loop(3, 2);
    prog[0][8] = 32'h8000_0000;
    do_run("loop", 0, NEVER, 0, NEVER, NEVER, l0);
    check("loop_load0_count", 64'(l0), 64'(3));

    // Cycle budget ends a run without halts; flag persists while idle
    clear_progs();
    do_run("budget", 10, NEVER, 0, NEVER, NEVER, l0);
    repeat (3) next_cycle();
    #1;
    check("budget_tmo_sticky", 64'(timeout_o), 64'(1));

    // Both end conditions together: all-halted wins, no timeout
    clear_progs();
    halt_all_at(5);
    do_run("both_end", 6, NEVER, 0, NEVER, NEVER, l0);

    // Five-cycle stall mid-run
    do_run("stall", 0, 2, 5, NEVER, NEVER, l0);

    // HALT+LOOP word in column 0, start re-pulsed mid-run
    clear_progs();
    halt_all_at(5);
    prog[0][5] = 32'h0;
    prog[0][3] = {2'b11, 8'd3, 10'd0, 12'd2};
    do_run("halt_loop", 0, NEVER, 0, NEVER, 2, l0);

    // Reset at RUN cycle 3
    clear_progs();
    halt_all_at(5);
    do_run("abort", 0, NEVER, 0, 3, NEVER, l0);

    // Randomized programs, budgets, stalls and start re-pulses
    for (int r = 0; r < 8; r++) begin
      int bud, sat, slen, rep;
      gen_random();
      bud  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(40, 3)) : 0;
      sat  = int'($urandom_range(15, 0));
      slen = int'($urandom_range(6, 0));
      rep  = int'($urandom_range(20, 1));
      do_run("rand", bud, sat, slen, NEVER, rep, l0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
